// File: rtl/if_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// if_prefetch_pkg
//   Shared constants for the Riscv151 instruction-fetch front end.
//   PC_RESET_VAL : first fetch address after reset
//   INSTR_NOP    : encoding presented on the instruction bus when nothing is
//                  queued (addi x0, x0, 0)
//   FETCH_DEPTH  : core-level default depth of the prefetch queue
// -----------------------------------------------------------------------------
package if_prefetch_pkg;

  localparam logic [31:0] PC_RESET_VAL = 32'h0000_2000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam int unsigned FETCH_DEPTH  = 4;

endpackage : if_prefetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO holding {pc, instruction} pairs for the prefetch queue.
//   The head entry is presented combinationally from storage (show-ahead), so
//   the consumer sees the oldest entry without a read latency.
//
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   flush_i   in   drop all entries (pointers and count to zero); wins over
//                  any write or read in the same cycle
//   wr_en_i   in   push wr_data_i (ignored when full)
//   wr_data_i in   WIDTH-bit entry
//   rd_en_i   in   pop the head (ignored when empty)
//   rd_data_o out  head entry; only meaningful while !empty_o
//   count_o   out  occupied entries, 0..DEPTH
//   empty_o   out  no entries
//   full_o    out  DEPTH entries
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_wr   = wr_en_i & ~full_o  & ~flush_i;
  assign do_rd   = rd_en_i & ~empty_o & ~flush_i;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; count_q alone decides which entries are live,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule : fetch_fifo

// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
//   Decoupled instruction-fetch front end. Issues sequential word fetches to
//   the instruction cache, tracks the single outstanding request across
//   memory stalls, buffers returned words with their PCs in a fetch_fifo and
//   restarts at the EX redirect target on a taken branch/jump.
//
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   redirect_valid in   EX redirect request (highest priority)
//   redirect_pc    in   redirect target; bits [1:0] ignored
//   stall          in   memory stall; cache neither samples nor advances
//   icache_addr    out  fetch address (registered fetch PC)
//   icache_re      out  request strobe; sampled by cache when !stall
//   icache_dout    in   read data, valid one unstalled cycle after sampling
//   inst_valid     out  queue head valid
//   inst           out  head instruction, INSTR_NOP when empty
//   inst_pc        out  head PC, last popped PC when empty
//   inst_ready     in   EX consumes the head this cycle
//   count          out  occupied queue entries
// -----------------------------------------------------------------------------
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter  int unsigned     XLEN     = 32,
  parameter  int unsigned     DEPTH    = FETCH_DEPTH,
  parameter  logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_VAL),
  localparam int unsigned     CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             stall,
  output logic [XLEN-1:0]  icache_addr,
  output logic             icache_re,
  input  logic [XLEN-1:0]  icache_dout,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             inst_ready,
  output logic [CNT_W-1:0] count
);

  localparam logic [XLEN-1:0] NOP_WORD = XLEN'(INSTR_NOP);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   req_pc_q,   req_pc_d;
  logic [XLEN-1:0]   last_pc_q,  last_pc_d;
  logic              req_valid_q, req_valid_d;

  logic              credit_ok, issue, fire, capture, pop;
  logic              fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [2*XLEN-1:0] fifo_head;
  logic [XLEN-1:0]   head_pc, head_inst;

  // A request may only go out if its word is guaranteed a free slot on
  // return: queued entries plus the one in flight must stay below DEPTH.
  assign credit_ok = ~fifo_full & ~(req_valid_q & (fifo_count == CNT_W'(DEPTH - 1)));
  assign issue     = ~redirect_valid & credit_ok;
  assign fire      = issue & ~stall;
  // A redirect discards the returning word and blocks the pop.
  assign capture   = req_valid_q & ~stall & ~redirect_valid;
  assign pop       = ~fifo_empty & inst_ready & ~redirect_valid;

  // Gating with reset keeps the strobe low for the whole reset window
  // while still allowing the first fetch in the cycle reset is released.
  assign icache_re   = reset & issue;
  assign icache_addr = fetch_pc_q;

  // NOTE: defaults are assigned first so every path sets every _d signal;
  // a missing default here would infer a latch.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    last_pc_d   = last_pc_q;

    if (redirect_valid) begin
      fetch_pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      req_valid_d = 1'b0;
    end else begin
      if (fire) begin
        req_pc_d    = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + XLEN'(4);
        req_valid_d = 1'b1;
      end else if (capture) begin
        req_valid_d = 1'b0;
      end
      if (pop) last_pc_d = head_pc;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q  <= PC_RESET;
      req_pc_q    <= PC_RESET;
      req_valid_q <= 1'b0;
      last_pc_q   <= PC_RESET;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      last_pc_q   <= last_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush_i   (redirect_valid),
    .wr_en_i   (capture),
    .wr_data_i ({req_pc_q, icache_dout}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign head_pc   = fifo_head[2*XLEN-1:XLEN];
  assign head_inst = fifo_head[XLEN-1:0];

  assign inst_valid = ~fifo_empty;
  assign inst       = fifo_empty ? NOP_WORD  : head_inst;
  assign inst_pc    = fifo_empty ? last_pc_q : head_pc;
  assign count      = fifo_count;

endmodule : if_prefetch

// File: tb/tb_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch
//   Self-checking bench for if_prefetch (XLEN=32, DEPTH=4). A cache model
//   returns addr ^ 32'hFFFF0000. A stream model tracks the PC the next pop
//   must carry: PC_RESET after reset, the word-aligned target after a
//   redirect, +4 after each pop.
// -----------------------------------------------------------------------------
module tb_if_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] PC_R  = 32'h0000_2000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] MASK  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] icache_dout = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;
  logic [2:0]  count;

  int          total = 0;
  int          bad   = 0;
  int          pops  = 0;
  logic [31:0] exp_pc = PC_R;

  always #5 clk = ~clk;

  if_prefetch dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .icache_addr    (icache_addr),
    .icache_re      (icache_re),
    .icache_dout    (icache_dout),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .count          (count)
  );

  // Instruction cache: samples on an unstalled strobe, holds while stalled.
  always @(posedge clk) begin
    if (icache_re && !stall) icache_dout <= icache_addr ^ MASK;
  end

  // Stream model and per-cycle invariants, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      exp_pc = PC_R;
    end else if (redirect_valid) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (inst_valid && inst_ready) begin
        total++;
        if (inst_pc !== exp_pc || inst !== (exp_pc ^ MASK)) begin
          bad++;
          $display("FAIL pop_stream: got pc=%h inst=%h, required pc=%h inst=%h", inst_pc, inst, exp_pc, exp_pc ^ MASK);
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      total++;
      if (count > 3'(DEPTH) || (!inst_valid && inst !== NOP)) begin
        bad++;
        $display("FAIL occupancy: got count=%0d valid=%b inst=%h, required count<=%0d and nop when empty", count, inst_valid, inst, DEPTH);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", inst_valid); end
    total++; if (inst !== NOP) begin bad++; $display("FAIL rst_inst: got %h required %h", inst, NOP); end
    total++; if (inst_pc !== PC_R) begin bad++; $display("FAIL rst_pc: got %h required %h", inst_pc, PC_R); end
    total++; if (icache_re !== 1'b0) begin bad++; $display("FAIL rst_re: got %b required 0", icache_re); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d required 0", count); end
    reset = 1'b1;
    @(negedge clk);  // cycle 0
    total++; if (icache_re !== 1'b1 || icache_addr !== PC_R) begin bad++; $display("FAIL start_issue: got re=%b addr=%h required re=1 addr=%h", icache_re, icache_addr, PC_R); end
    @(negedge clk);  // cycle 1
    total++; if (inst_valid !== 1'b0 || icache_addr !== PC_R + 32'd4) begin bad++; $display("FAIL start_c1: got valid=%b addr=%h required valid=0 addr=%h", inst_valid, icache_addr, PC_R + 32'd4); end
    @(negedge clk);  // cycle 2
    total++; if (inst_valid !== 1'b1 || inst_pc !== PC_R || inst !== (PC_R ^ MASK)) begin bad++; $display("FAIL start_c2: got valid=%b pc=%h inst=%h required 1 %h %h", inst_valid, inst_pc, inst, PC_R, PC_R ^ MASK); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (inst_valid !== 1'b1 || inst_pc !== PC_R + 32'(4 * (k + 1)) || count !== 3'd1) begin
        bad++;
        $display("FAIL stream_%0d: got valid=%b pc=%h count=%0d required 1 %h 1", k, inst_valid, inst_pc, count, PC_R + 32'(4 * (k + 1)));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    repeat (3) @(negedge clk);
    @(posedge clk); #1; stall = 1'b1;     // S1
    @(posedge clk); #1; held = exp_pc;    // S2: word in flight
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (count !== 3'd0 || inst_valid !== 1'b0 || icache_addr !== held + 32'd4 || inst_pc !== held - 32'd4) begin
        bad++;
        $display("FAIL stall_hold_%0d: got count=%0d valid=%b addr=%h pc=%h required 0 0 %h %h", k, count, inst_valid, icache_addr, inst_pc, held + 32'd4, held - 32'd4);
      end
    end
    @(posedge clk); #1; stall = 1'b0;     // first unstalled cycle
    @(negedge clk);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL stall_release: got count=%0d required 0", count); end
    @(negedge clk);
    total++; if (inst_valid !== 1'b1 || inst_pc !== held || inst !== (held ^ MASK)) begin bad++; $display("FAIL stall_capture: got valid=%b pc=%h inst=%h required 1 %h %h", inst_valid, inst_pc, inst, held, held ^ MASK); end
  endtask

  task automatic test_redirect();
    bit hit = 1'b0;
    @(posedge clk); #1; inst_ready = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (count == 3'd2) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL redir_fill: got timeout, required count=2"); end
    @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h0000_3006;  // N
    @(negedge clk);
    total++; if (count !== 3'd3 || icache_re !== 1'b0) begin bad++; $display("FAIL redir_n: got count=%0d re=%b required 3 0", count, icache_re); end
    @(posedge clk); #1; redirect_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);  // N+1
    total++; if (count !== 3'd0 || icache_addr !== 32'h0000_3004 || icache_re !== 1'b1) begin bad++; $display("FAIL redir_n1: got count=%0d addr=%h re=%b required 0 00003004 1", count, icache_addr, icache_re); end
    @(negedge clk);  // N+2
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_n2: got valid=%b required 0", inst_valid); end
    @(negedge clk);  // N+3
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_3004) begin bad++; $display("FAIL redir_n3: got valid=%b pc=%h required 1 00003004", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_combo();
    logic [31:0] h;
    // Redirect in the same cycle as a pop and a capture.
    repeat (4) @(negedge clk);
    @(posedge clk); #1; h = exp_pc; redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (count !== 3'd0 || inst_pc !== h - 32'd4 || icache_addr !== 32'h0000_4000) begin bad++; $display("FAIL combo_pop: got count=%0d pc=%h addr=%h required 0 %h 00004000", count, inst_pc, icache_addr, h - 32'd4); end
    repeat (2) @(negedge clk);
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_4000) begin bad++; $display("FAIL combo_pop_n3: got valid=%b pc=%h required 1 00004000", inst_valid, inst_pc); end
    // Redirect while the memory system is stalled.
    repeat (3) @(negedge clk);
    @(posedge clk); #1; stall = 1'b1;
    @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h0000_5009;
    @(posedge clk); #1; redirect_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    total++; if (count !== 3'd0 || inst_valid !== 1'b0 || icache_addr !== 32'h0000_5008) begin bad++; $display("FAIL combo_stall: got count=%0d valid=%b addr=%h required 0 0 00005008", count, inst_valid, icache_addr); end
    repeat (2) @(negedge clk);
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_5008) begin bad++; $display("FAIL combo_stall_n3: got valid=%b pc=%h required 1 00005008", inst_valid, inst_pc); end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1; inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (count !== 3'(DEPTH) || icache_re !== 1'b0 || inst_pc !== exp_pc) begin bad++; $display("FAIL bp_full: got count=%0d re=%b pc=%h required %0d 0 %h", count, icache_re, inst_pc, DEPTH, exp_pc); end
    total++; if (icache_addr !== exp_pc + 32'd16) begin bad++; $display("FAIL bp_addr: got %h required %h", icache_addr, exp_pc + 32'd16); end
    repeat (2) @(negedge clk);
    total++; if (icache_addr !== exp_pc + 32'd16 || count !== 3'(DEPTH)) begin bad++; $display("FAIL bp_frozen: got addr=%h count=%0d required %h %0d", icache_addr, count, exp_pc + 32'd16, DEPTH); end
    @(posedge clk); #1; inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL bp_drain_%0d: got valid=%b required 1", k, inst_valid); end
    end
  endtask

  task automatic test_random();
    int start_pops;
    start_pops = pops;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      stall      = ($urandom_range(0, 3) == 0);
      inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : 32'h0000_8000 + $urandom_range(0, 4095);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1; stall = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (pops - start_pops < 100) begin bad++; $display("FAIL rand_progress: got %0d pops required >=100", pops - start_pops); end
  endtask

  task automatic test_async_reset();
    bit hit = 1'b0;
    @(posedge clk); #1; inst_ready = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge clk);
      if (count == 3'(DEPTH)) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL areset_fill: got timeout, required full queue"); end
    @(posedge clk); #3; reset = 1'b0; #1;
    total++; if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== PC_R) begin bad++; $display("FAIL areset_out: got valid=%b inst=%h pc=%h required 0 %h %h", inst_valid, inst, inst_pc, NOP, PC_R); end
    total++; if (icache_re !== 1'b0 || count !== 3'd0 || icache_addr !== PC_R) begin bad++; $display("FAIL areset_fetch: got re=%b count=%0d addr=%h required 0 0 %h", icache_re, count, icache_addr, PC_R); end
    @(negedge clk);
    @(posedge clk); #1; reset = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    total++; if (icache_re !== 1'b1 || icache_addr !== PC_R) begin bad++; $display("FAIL areset_restart: got re=%b addr=%h required 1 %h", icache_re, icache_addr, PC_R); end
    repeat (2) @(negedge clk);
    total++; if (inst_valid !== 1'b1 || inst_pc !== PC_R) begin bad++; $display("FAIL areset_first: got valid=%b pc=%h required 1 %h", inst_valid, inst_pc, PC_R); end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_combo();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_prefetch
